bsr_shift_ctrl: RTL and testbench

//  Command-driven sequencer for the 4-bit bidirectional shift register (bsr).
//  - Accepts {direction, length, data} over a valid/ready handshake.
//  - Serialises the data LSB-first onto the bsr ri/li inputs and drives rl_mode.
//  - Samples the bsr q output once the last bit has landed and returns it on a valid/ready response.
//  - Sits between a host or test sequencer and one bsr instance; the bsr remains free-running, with no enable.

---
 rtl/bsr_pkg.sv | 17 +
 rtl/bsr.sv | 32 +++
 rtl/bsr_shift_ctrl.sv | 130 +++++++++++++
 tb/tb_bsr_shift_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bsr_pkg.sv
// Shared definitions for the bidirectional shift register (bsr) and its
// command sequencer: controller state encoding and shift-direction values.
package bsr_pkg;

   // Controller sequence: IDLE -> SHIFT -> CAPTURE -> RESP -> IDLE
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // Shift direction as carried on cmd_dir and rl_mode
   localparam logic DIR_RIGHT = 1'b0;   // ri lane, inserts at q[REG_W-1]
   localparam logic DIR_LEFT  = 1'b1;   // li lane, inserts at q[0]

endpackage

// File: rtl/bsr.sv
// Free-running REG_W-bit bidirectional shift register. Shifts every clock.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, clears q
//   ri       serial input for right shift, enters at q[REG_W-1]
//   li       serial input for left shift, enters at q[0]
//   rl_mode  DIR_RIGHT / DIR_LEFT
//   q        parallel register contents
module bsr
   import bsr_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ri,
   input  logic             li,
   input  logic             rl_mode,
   output logic [REG_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (rl_mode == DIR_LEFT) begin
         q <= {q[REG_W-2:0], li};
      end else begin
         q <= {ri, q[REG_W-1:1]};
      end
   end

endmodule

// File: rtl/bsr_shift_ctrl.sv
// Command-driven sequencer for one bsr instance. Accepts {dir, len, data}
// over a valid/ready handshake, serialises data LSB-first onto ri or li,
// samples q once the last bit has landed and returns it on a valid/ready
// response.
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_dir              DIR_RIGHT (ri lane) / DIR_LEFT (li lane)
//   cmd_len              bits to shift, legal 1..DATA_W
//   cmd_data             serial payload, bit 0 first
//   abort                synchronous abort to IDLE, no response
//   ri, li, rl_mode      registered drives to the bsr
//   q_in                 bsr q
//   rsp_valid/rsp_ready  response handshake, rsp_data = captured q_in
//   busy                 not in IDLE
//   err                  one-cycle pulse on a rejected illegal cmd_len
module bsr_shift_ctrl
   import bsr_pkg::*;
#(
   parameter int   REG_W     = 4,
   parameter int   DATA_W    = 8,
   parameter int   LEN_W     = 4,
   parameter logic IDLE_FILL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              abort,
   output logic              ri,
   output logic              li,
   output logic              rl_mode,
   input  logic [REG_W-1:0]  q_in,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [REG_W-1:0]  rsp_data,
   output logic              busy,
   output logic              err
);

   state_t              state;
   logic                dir_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt;
   // Remaining payload; bit 0 is always the next bit to drive
   logic [DATA_W-1:0]   data_q;

   logic len_bad;
   assign len_bad   = (cmd_len == '0) || (cmd_len > LEN_W'(DATA_W));
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // NOTE: every register here is assigned with <= so all branches act on
   // the pre-edge values, matching what the flops actually do.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ri        <= IDLE_FILL;
         li        <= IDLE_FILL;
         rl_mode   <= DIR_RIGHT;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         err       <= 1'b0;
         dir_q     <= DIR_RIGHT;
         len_q     <= '0;
         cnt       <= '0;
         data_q    <= '0;
      end else begin
         err <= 1'b0;
         if (abort) begin
            // Abort outranks accept and response handshake; rsp_data is kept
            state     <= ST_IDLE;
            ri        <= IDLE_FILL;
            li        <= IDLE_FILL;
            rsp_valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  ri <= IDLE_FILL;
                  li <= IDLE_FILL;
                  if (cmd_valid) begin
                     if (len_bad) begin
                        err <= 1'b1;
                     end else begin
                        dir_q   <= cmd_dir;
                        len_q   <= cmd_len;
                        data_q  <= cmd_data >> 1;
                        cnt     <= LEN_W'(1);
                        rl_mode <= cmd_dir;
                        if (cmd_dir == DIR_LEFT) li <= cmd_data[0];
                        else                     ri <= cmd_data[0];
                        state   <= ST_SHIFT;
                     end
                  end
               end
               ST_SHIFT: begin
                  // cnt bits have been presented; the last one lands this edge
                  if (cnt == len_q) begin
                     ri    <= IDLE_FILL;
                     li    <= IDLE_FILL;
                     state <= ST_CAPTURE;
                  end else begin
                     if (dir_q == DIR_LEFT) li <= data_q[0];
                     else                   ri <= data_q[0];
                     data_q <= data_q >> 1;
                     cnt    <= cnt + LEN_W'(1);
                  end
               end
               ST_CAPTURE: begin
                  // q_in still holds the shifted result; the bsr moves on at this edge
                  rsp_data  <= q_in;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
               ST_RESP: begin
                  if (rsp_ready) begin
                     rsp_valid <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bsr_shift_ctrl.sv
// Directed bench for bsr_shift_ctrl driving a real bsr instance.
module tb_bsr_shift_ctrl;
   import bsr_pkg::*;

   localparam int REG_W  = 4;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready, cmd_dir;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_data;
   logic              abort;
   logic              ri, li, rl_mode;
   logic [REG_W-1:0]  q;
   logic              rsp_valid, rsp_ready;
   logic [REG_W-1:0]  rsp_data;
   logic              busy, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bsr_shift_ctrl #(.REG_W(REG_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .IDLE_FILL(1'b0)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_len(cmd_len), .cmd_data(cmd_data), .abort(abort),
      .ri(ri), .li(li), .rl_mode(rl_mode), .q_in(q),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .err(err)
   );

   bsr #(.REG_W(REG_W)) u_bsr (
      .clk(clk), .rst(rst), .ri(ri), .li(li), .rl_mode(rl_mode), .q(q)
   );

   typedef struct {
      logic              dir;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] data;
      logic [REG_W-1:0]  exp;
      int                hold;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Step to 1ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one legal command and follow it through to the response handshake
   task automatic run_cmd(input logic dir, input logic [LEN_W-1:0] len,
                          input logic [DATA_W-1:0] data, input logic [REG_W-1:0] exp,
                          input int hold, input string tag);
      logic lanes_ok;
      int   lat;
      cmd_valid = 1'b1; cmd_dir = dir; cmd_len = len; cmd_data = data;
      tick();   // accept edge E0
      cmd_valid = 1'b0;
      check({tag, " rl_mode"}, 32'(rl_mode), 32'(dir));
      lanes_ok = 1'b1;
      for (int i = 0; i < int'(len); i++) begin
         if (dir == DIR_LEFT) begin
            if (li !== data[i] || ri !== 1'b0) lanes_ok = 1'b0;
         end else begin
            if (ri !== data[i] || li !== 1'b0) lanes_ok = 1'b0;
         end
         if (busy !== 1'b1 || rsp_valid !== 1'b0) lanes_ok = 1'b0;
         tick();
      end
      check({tag, " lanes"}, 32'(lanes_ok), 32'd1);
      lat = int'(len);
      while (rsp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(int'(len) + 1));
      check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp));
      for (int h = 0; h < hold; h++) begin
         tick();
         check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
         check({tag, " hold data"}, 32'(rsp_data), 32'(exp));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, " rsp drop"}, 32'({rsp_valid, cmd_ready}), 32'b01);
      tick();
      tick();
   endtask

   initial begin
      // {dir, len, data, expected q, rsp_ready stall cycles}
      vecs[0] = '{DIR_RIGHT, 4'd4, 8'h0B, 4'b1011, 0};
      vecs[1] = '{DIR_LEFT,  4'd4, 8'h0B, 4'b1101, 0};
      vecs[2] = '{DIR_RIGHT, 4'd8, 8'hA5, 4'b1010, 3};
      vecs[3] = '{DIR_LEFT,  4'd8, 8'hA5, 4'b0101, 0};
      vecs[4] = '{DIR_RIGHT, 4'd1, 8'h01, 4'b1000, 1};
      vecs[5] = '{DIR_LEFT,  4'd2, 8'h02, 4'b0001, 0};

      rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; cmd_data = '0;
      abort = 1'b0; rsp_ready = 1'b0;
      #10;
      check("reset outputs", 32'({ri, li, rl_mode, rsp_valid, cmd_ready, busy, err}), 32'b0000100);
      check("reset rsp_data", 32'(rsp_data), 32'd0);
      #2 rst = 1'b0;
      tick();
      tick();

      for (int v = 0; v < 6; v++)
         run_cmd(vecs[v].dir, vecs[v].len, vecs[v].data, vecs[v].exp, vecs[v].hold,
                 $sformatf("vec%0d", v));

      // Illegal lengths: err pulse, stay IDLE, drives untouched (rl_mode left at 1)
      cmd_valid = 1'b1; cmd_dir = DIR_RIGHT; cmd_len = 4'd0; cmd_data = 8'hFF;
      tick();
      cmd_valid = 1'b0;
      check("len0 err", 32'({err, busy, ri, li, rl_mode}), 32'b10001);
      tick();
      check("len0 pulse", 32'({err, busy, rsp_valid}), 32'b000);
      cmd_valid = 1'b1; cmd_len = 4'd9;
      tick();
      cmd_valid = 1'b0;
      check("len9 err", 32'({err, busy, ri, li, rl_mode}), 32'b10001);
      tick();
      check("len9 pulse", 32'({err, busy, rsp_valid}), 32'b000);

      // Abort in IDLE drops a same-cycle legal command
      abort = 1'b1; cmd_valid = 1'b1; cmd_dir = DIR_RIGHT; cmd_len = 4'd4; cmd_data = 8'h0F;
      tick();
      abort = 1'b0; cmd_valid = 1'b0;
      check("idle abort", 32'({busy, err, rl_mode}), 32'b001);

      // Abort on the second SHIFT cycle
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort idle", 32'({busy, rsp_valid, ri, li}), 32'b0000);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
         end
         check("abort no rsp", 32'(seen), 32'd0);
      end

      // Response handshake with a waiting command: accepted one edge later
      cmd_valid = 1'b1; cmd_dir = DIR_LEFT; cmd_len = 4'd4; cmd_data = 8'h0B;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("b2b rsp", 32'({rsp_valid, rsp_data}), 32'b11101);
      rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_dir = DIR_RIGHT; cmd_data = 8'h03;
      tick();
      rsp_ready = 1'b0;
      check("b2b not taken", 32'({busy, rsp_valid, cmd_ready}), 32'b001);
      tick();
      cmd_valid = 1'b0;
      check("b2b taken", 32'({busy, rl_mode, ri}), 32'b101);

      // Async reset in the middle of SHIFT
      #3 rst = 1'b1;
      #1;
      check("midreset", 32'({ri, li, rl_mode, rsp_valid, cmd_ready, busy}), 32'b000010);
      check("midreset data", 32'(rsp_data), 32'd0);
      #10 rst = 1'b0;
      tick();
      run_cmd(DIR_RIGHT, 4'd4, 8'h0B, 4'b1011, 0, "post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
